// File: rtl/player_powerup_timer_if.sv
// Pickup inputs and HUD/pixel-stage outputs of the power-up timer.
// The master side is the game logic; the slave side is the timer.
interface player_powerup_timer_if;
  logic        game_active;
  logic        pickup_invincible;
  logic        pickup_speedy;
  logic        player_is_invincible;
  logic        player_is_speedy;
  logic [15:0] invincible_ms_left;
  logic [15:0] speedy_ms_left;
  logic        powerup_warning;
  logic        powerup_expired;

  modport master (
    output game_active, pickup_invincible, pickup_speedy,
    input  player_is_invincible, player_is_speedy,
    input  invincible_ms_left, speedy_ms_left,
    input  powerup_warning, powerup_expired
  );

  modport slave (
    input  game_active, pickup_invincible, pickup_speedy,
    output player_is_invincible, player_is_speedy,
    output invincible_ms_left, speedy_ms_left,
    output powerup_warning, powerup_expired
  );
endinterface

// File: rtl/player_powerup_timer.sv
// Millisecond countdowns for invincibility and speed-boost power-ups.
// Define POWERUP_STACK_EN to make re-pickups add time (saturating).
module player_powerup_timer #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int INVINCIBLE_MS = 5000,
  parameter int SPEEDY_MS     = 5000,
  parameter int WARN_MS       = 1000
) (
  input logic clock_100mhz,
  input logic reset_n,
  player_powerup_timer_if.slave bus
);
  localparam int DIV = CLK_HZ / 1000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [1:0][15:0] DUR =
    {16'(SPEEDY_MS), 16'(INVINCIBLE_MS)};
  localparam logic [15:0] WARN_L = 16'(WARN_MS);

  typedef enum logic [1:0] {IDLE, ACTIVE, WARN} state_t;

  logic [PW-1:0] pre_q;
  logic          tick;
  state_t        state_q [2];
  state_t        state_d [2];
  logic [15:0]   cnt_q [2];
  logic [15:0]   cnt_d [2];
  logic [15:0]   nxt [2];
  logic [1:0]    pick;
  logic [1:0]    expire;
  logic          inv_q, spd_q, warn_q, exp_q;
`ifdef POWERUP_STACK_EN
  logic [16:0]   sum [2];
`endif

  assign tick = bus.game_active && (pre_q == PW'(DIV - 1));
  assign pick = {bus.pickup_speedy, bus.pickup_invincible};

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else if (!bus.game_active || tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  // Pickup takes priority over a same-cycle tick.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      nxt[i]     = cnt_q[i];
      expire[i]  = 1'b0;
`ifdef POWERUP_STACK_EN
      sum[i]     = {1'b0, cnt_q[i]} + {1'b0, DUR[i]};
`endif
      if (!bus.game_active) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else if (pick[i]) begin
`ifdef POWERUP_STACK_EN
        nxt[i] = sum[i][16] ? 16'hFFFF : sum[i][15:0];
`else
        nxt[i] = DUR[i];
`endif
        cnt_d[i]   = nxt[i];
        state_d[i] = (nxt[i] <= WARN_L) ? WARN : ACTIVE;
      end else if (tick && state_q[i] != IDLE
                   && cnt_q[i] != '0) begin
        nxt[i]   = cnt_q[i] - 16'd1;
        cnt_d[i] = nxt[i];
        if (nxt[i] == '0) begin
          state_d[i] = IDLE;
          expire[i]  = 1'b1;
        end else if (nxt[i] <= WARN_L) begin
          state_d[i] = WARN;
        end
      end
    end
  end

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      inv_q  <= 1'b0;
      spd_q  <= 1'b0;
      warn_q <= 1'b0;
      exp_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      inv_q  <= (state_d[0] != IDLE);
      spd_q  <= (state_d[1] != IDLE);
      warn_q <= (state_d[0] == WARN) || (state_d[1] == WARN);
      exp_q  <= |expire;
    end
  end

  assign bus.player_is_invincible = inv_q;
  assign bus.player_is_speedy     = spd_q;
  assign bus.invincible_ms_left   = cnt_q[0];
  assign bus.speedy_ms_left       = cnt_q[1];
  assign bus.powerup_warning      = warn_q;
  assign bus.powerup_expired      = exp_q;
endmodule

// File: doc/player_powerup_timer.md
# player_powerup_timer

Tracks the player's timed power-ups, invincibility and speed boost, and drives the `player_is_invincible` / `player_is_speedy` flags consumed by the player pixel-colour stage. Pickup pulses from the collision logic start per-power-up millisecond countdowns. Each countdown runs only while the game is active and expires automatically. The block also exports remaining time and an expiry-warning flag for the HUD.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, clock frequency; the 1 ms tick period is `CLK_HZ/1000` cycles.
- `INVINCIBLE_MS`, 5000, invincibility duration in ms (1..65535).
- `SPEEDY_MS`, 5000, speed-boost duration in ms (1..65535).
- `WARN_MS`, 1000, warning window before expiry in ms (< both durations).

Ports:
- `clock_100mhz` input 1: system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `game_active` input 1: high while a round is running.
- `pickup_invincible` input 1: single-cycle pickup pulse.
- `pickup_speedy` input 1: single-cycle pickup pulse.
- `player_is_invincible` output 1: invincibility active.
- `player_is_speedy` output 1: speed boost active.
- `invincible_ms_left` output 16: remaining invincibility ms.
- `speedy_ms_left` output 16: remaining speed-boost ms.
- `powerup_warning` output 1: any active power-up has ≤ `WARN_MS` left.
- `powerup_expired` output 1: one-cycle pulse when either power-up reaches 0 by countdown.

## Operation
- Prescaler: counts 0..`CLK_HZ/1000-1` while `game_active`. Wrapping to 0 produces the internal `ms_tick`. It is held at 0 while `!game_active`.
- Each power-up has an independent FSM with states IDLE, ACTIVE and WARN, and a 16-bit counter `ms_left`.
  - IDLE → ACTIVE on pickup; `ms_left` loads the duration parameter.
  - ACTIVE → WARN when a tick brings `ms_left` to ≤ `WARN_MS`.
  - WARN → IDLE when a tick brings `ms_left` to 0; `powerup_expired` pulses.
  - ACTIVE or WARN plus pickup: the counter is reloaded (see Configuration) and the state is re-evaluated from the new `ms_left`.
- Flag outputs:
  - `player_is_*` = (state ≠ IDLE).
  - `powerup_warning` = either FSM in WARN.
  - `*_ms_left` mirrors the counter; it is 0 in IDLE.
- Simultaneous events:
  - Pickup and `ms_tick` in the same cycle: the pickup wins; no decrement that cycle.
  - Both pickups in the same cycle: both are loaded.
  - Both power-ups expiring on the same tick: a single `powerup_expired` pulse.
- `game_active` low: both FSMs go to IDLE, counters and the prescaler clear, and pickups are ignored. No `powerup_expired` pulse is generated for this clear.
- Counter arithmetic is unsigned 16-bit. A decrement is never applied at 0.

## Timing
- Reset (async assert, sync release): all outputs are 0, FSMs are IDLE, counters and the prescaler are 0.
- All outputs are registered.
- Pickup at edge N: the flag is high and `ms_left` equals the duration after edge N.
- Expiry: the flag drops on the same edge at which the tick brings `ms_left` to 0. `powerup_expired` is high for exactly that one cycle.
- Active duration from pickup edge to flag low: duration × `CLK_HZ/1000` cycles ± one tick period. The prescaler is not realigned on pickup.
- `reset_n` asserted mid-countdown: immediate clear, no expiry pulse.

## Configuration
- `POWERUP_STACK_EN` defined: a pickup while ACTIVE or WARN adds the duration to `ms_left`, saturating at 65535.
- `POWERUP_STACK_EN` undefined: a pickup while ACTIVE or WARN reloads `ms_left` to the duration.
- A pickup from IDLE behaves identically in both builds.

## Test plan
All scenarios use `CLK_HZ`=10_000 (tick every 10 cycles), `INVINCIBLE_MS`=20, `SPEEDY_MS`=30, `WARN_MS`=5.
- Reset then idle with `game_active`=1: all outputs stay 0 for 500 cycles.
- `pickup_invincible` pulse:
  - `player_is_invincible`=1 and `invincible_ms_left`=20 next cycle.
  - `powerup_warning` rises when `ms_left`=5.
  - The flag drops with a one-cycle `powerup_expired` ~200 cycles later.
- Both pickups in the same cycle: both flags rise. Invincibility drops at ms_left 0 (~200 cycles), speed at ~300 cycles. Two separate expiry pulses.
- Re-pickup when `invincible_ms_left`=3 (state WARN):
  - Without `POWERUP_STACK_EN`: reads 20, `powerup_warning` clears.
  - With `POWERUP_STACK_EN`: reads 23.
- Stack build, 4000 pickups of `INVINCIBLE_MS`=20: `invincible_ms_left` saturates at 65535, no wrap.
- `game_active` drops with `speedy_ms_left`=12: next cycle all outputs are 0 and no expiry pulse. A pickup while inactive is ignored. `reset_n` low mid-countdown clears asynchronously.
